// File: rtl/gate_exerciser_pkg.sv
// gate_ex_pkg -- shared definitions for the gate exerciser.
//   state_t         : FSM state encoding of gate_exerciser
//   GATE_W          : width of the gate result vector
//   NUM_VECTORS     : number of {a,b} stimulus vectors per run
//   *_BIT           : bit positions of each gate result inside gate_in
//   expected_gates(): golden 7-bit result for a given (a,b)
package gate_ex_pkg;

  localparam int GATE_W      = 7;
  localparam int NUM_VECTORS = 4;

  localparam int AND_BIT  = 6;
  localparam int OR_BIT   = 5;
  localparam int NAND_BIT = 4;
  localparam int NOR_BIT  = 3;
  localparam int NOT_BIT  = 2;
  localparam int XOR_BIT  = 1;
  localparam int XNOR_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  function automatic logic [GATE_W-1:0] expected_gates(input logic a, input logic b);
    logic [GATE_W-1:0] r;
    r           = '0;
    r[AND_BIT]  = a & b;
    r[OR_BIT]   = a | b;
    r[NAND_BIT] = ~(a & b);
    r[NOR_BIT]  = ~(a | b);
    r[NOT_BIT]  = ~a;
    r[XOR_BIT]  = a ^ b;
    r[XNOR_BIT] = ~(a ^ b);
    return r;
  endfunction

endpackage

// File: rtl/gate_exerciser_if.sv
// gate_exerciser_if -- control and stimulus/response bundle of the gate exerciser.
//   start    : request one exercise run
//   busy     : run in progress
//   done     : one-cycle end-of-run pulse
//   pass     : run result (no mismatching vectors)
//   a, b     : stimulus operands to the gate block under test
//   gate_in  : gate block results {and,or,nand,nor,not a,xor,xnor}
//   err_cnt  : number of mismatching vectors in the run
//   fail_idx : first failing vector index  (only with GATE_EX_FIRST_FAIL_EN)
//   fail_vec : gate_in at first failure    (only with GATE_EX_FIRST_FAIL_EN)
// Modports: master = the exerciser, slave = its environment.
interface gate_exerciser_if;

  logic                         start;
  logic                         busy;
  logic                         done;
  logic                         pass;
  logic                         a;
  logic                         b;
  logic [gate_ex_pkg::GATE_W-1:0] gate_in;
  logic [2:0]                   err_cnt;
`ifdef GATE_EX_FIRST_FAIL_EN
  logic [1:0]                   fail_idx;
  logic [gate_ex_pkg::GATE_W-1:0] fail_vec;
`endif

  modport master (
    input  start, gate_in,
    output busy, done, pass, a, b, err_cnt
`ifdef GATE_EX_FIRST_FAIL_EN
    , output fail_idx, fail_vec
`endif
  );

  modport slave (
    output start, gate_in,
    input  busy, done, pass, a, b, err_cnt
`ifdef GATE_EX_FIRST_FAIL_EN
    , input fail_idx, fail_vec
`endif
  );

endinterface

// File: rtl/gate_exerciser.sv
// gate_exerciser -- drives the four {a,b} vectors into a gate block, waits
// SETTLE_CYCLES after each, compares gate_in against the golden truth table
// and reports the number of mismatches and an overall pass flag.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : gate_exerciser_if.master (start/busy/done/pass/a/b/gate_in/err_cnt,
//            plus fail_idx/fail_vec when GATE_EX_FIRST_FAIL_EN is defined)
// Optional feature macro: GATE_EX_FIRST_FAIL_EN (first-failure capture).
// All outputs are registered.
module gate_exerciser
  import gate_ex_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  gate_exerciser_if.master   bus
);

  // Only meaningful when SETTLE_CYCLES > 0; SETTLE is unreachable otherwise.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t            state, state_nxt;
  logic [1:0]        idx;
  logic [3:0]        settle_cnt;
  logic              busy_r, done_r, pass_r, a_r, b_r;
  logic [2:0]        err_r;
`ifdef GATE_EX_FIRST_FAIL_EN
  logic [1:0]        fail_idx_r;
  logic [GATE_W-1:0] fail_vec_r;
`endif

  logic start_run, load_ab, settle_tick, do_check, finish, mismatch;

  assign mismatch = (bus.gate_in != expected_gates(a_r, b_r));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_run   = 1'b0;
    load_ab     = 1'b0;
    settle_tick = 1'b0;
    do_check    = 1'b0;
    finish      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          start_run = 1'b1;
          state_nxt = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        load_ab   = 1'b1;
        state_nxt = (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;
      end
      ST_SETTLE: begin
        settle_tick = 1'b1;
        if (settle_cnt == SETTLE_LAST) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        do_check  = 1'b1;
        state_nxt = (idx == 2'(NUM_VECTORS - 1)) ? ST_DONE : ST_DRIVE;
      end
      ST_DONE: begin
        finish    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
      a_r        <= 1'b0;
      b_r        <= 1'b0;
      err_r      <= '0;
      idx        <= '0;
      settle_cnt <= '0;
`ifdef GATE_EX_FIRST_FAIL_EN
      fail_idx_r <= '0;
      fail_vec_r <= '0;
`endif
    end else begin
      // busy/done track the state being entered so they line up with it
      busy_r <= (state_nxt != ST_IDLE);
      done_r <= finish;
      if (start_run) begin
        err_r  <= '0;
        pass_r <= 1'b0;
        idx    <= '0;
`ifdef GATE_EX_FIRST_FAIL_EN
        fail_idx_r <= '0;
        fail_vec_r <= '0;
`endif
      end
      if (load_ab) begin
        {a_r, b_r} <= idx;
        settle_cnt <= '0;
      end
      if (settle_tick) settle_cnt <= settle_cnt + 4'd1;
      if (do_check) begin
        if (mismatch) begin
          err_r <= err_r + 3'd1;
`ifdef GATE_EX_FIRST_FAIL_EN
          // err_r is still the pre-check count here, so this is the first miss
          if (err_r == 3'd0) begin
            fail_idx_r <= idx;
            fail_vec_r <= bus.gate_in;
          end
`endif
        end
        // idx saturates at the last vector; a new start clears it
        if (idx != 2'(NUM_VECTORS - 1)) idx <= idx + 2'd1;
      end
      // err_r already includes the final CHECK when DONE is reached
      if (finish) pass_r <= (err_r == 3'd0);
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.pass    = pass_r;
  assign bus.a       = a_r;
  assign bus.b       = b_r;
  assign bus.err_cnt = err_r;
`ifdef GATE_EX_FIRST_FAIL_EN
  assign bus.fail_idx = fail_idx_r;
  assign bus.fail_vec = fail_vec_r;
`endif

endmodule

// File: tb/tb_gate_exerciser.sv
// tb_gate_exerciser -- scoreboard bench for gate_exerciser.
// Two DUT instances: SETTLE_CYCLES=2 (bus2) and SETTLE_CYCLES=0 (bus0).
// A gate model per instance answers {a,b} from a truth table, optionally
// corrupted per vector; expected run results are queued at start and popped
// by monitors on each done pulse.
// Fail-capture fields are checked when GATE_EX_FIRST_FAIL_EN is defined.
module tb_gate_exerciser;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gate_exerciser_if bus2();
  gate_exerciser_if bus0();

  gate_exerciser #(.SETTLE_CYCLES(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  gate_exerciser #(.SETTLE_CYCLES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  // truth table indexed by {a,b}: {and,or,nand,nor,~a,xor,xnor}
  localparam logic [6:0] TT [4] = '{7'b0011101, 7'b0110110, 7'b0110010, 7'b1100001};

  logic [6:0] corr2 [4];
  logic [6:0] corr0 [4];

  assign bus2.gate_in = TT[{bus2.a, bus2.b}] ^ corr2[{bus2.a, bus2.b}];
  assign bus0.gate_in = TT[{bus0.a, bus0.b}] ^ corr0[{bus0.a, bus0.b}];

  logic [1:0] fi2, fi0;
  logic [6:0] fv2, fv0;
`ifdef GATE_EX_FIRST_FAIL_EN
  assign fi2 = bus2.fail_idx;  assign fv2 = bus2.fail_vec;
  assign fi0 = bus0.fail_idx;  assign fv0 = bus0.fail_vec;
`else
  assign fi2 = 2'd0;  assign fv2 = 7'd0;
  assign fi0 = 2'd0;  assign fv0 = 7'd0;
`endif

  typedef struct {
    int         done_edge;
    logic [2:0] err;
    logic       pass;
    logic [1:0] fidx;
    logic [6:0] fvec;
  } exp_t;

  exp_t q2[$];
  exp_t q0[$];
  exp_t last2, last0, mon_e2, mon_e0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Run outcome from the corruption table: each corrupted vector is one error.
  function automatic exp_t model(input logic [6:0] c [4], input int done_edge);
    exp_t e;
    e.done_edge = done_edge;
    e.err  = 3'd0;
    e.fidx = 2'd0;
    e.fvec = 7'd0;
    for (int i = 0; i < 4; i++) begin
      if (c[i] != 7'd0) begin
        if (e.err == 3'd0) begin
          e.fidx = 2'(i);
          e.fvec = TT[i] ^ c[i];
        end
        e.err = e.err + 3'd1;
      end
    end
    e.pass = (e.err == 3'd0);
    return e;
  endfunction

  task automatic compare_done(input string tag, input exp_t e, input int got_edge,
                              input logic [2:0] err, input logic pass, input logic a,
                              input logic b, input logic busy, input logic [1:0] fidx,
                              input logic [6:0] fvec);
    check({tag, "_latency"}, got_edge, e.done_edge);
    check({tag, "_err_cnt"}, err, e.err);
    check({tag, "_pass"}, pass, e.pass);
    check({tag, "_a_last"}, a, 1'b1);
    check({tag, "_b_last"}, b, 1'b1);
    check({tag, "_busy_at_done"}, busy, 1'b0);
`ifdef GATE_EX_FIRST_FAIL_EN
    check({tag, "_fail_idx"}, fidx, e.fidx);
    check({tag, "_fail_vec"}, fvec, e.fvec);
`endif
  endtask

  always @(negedge clk) begin
    if (bus2.done) begin
      if (q2.size() == 0) check("s2_unexpected_done", 1, 0);
      else begin
        mon_e2 = q2.pop_front();
        compare_done("s2", mon_e2, cyc, bus2.err_cnt, bus2.pass, bus2.a, bus2.b,
                     bus2.busy, fi2, fv2);
      end
    end
  end

  always @(negedge clk) begin
    if (bus0.done) begin
      if (q0.size() == 0) check("s0_unexpected_done", 1, 0);
      else begin
        mon_e0 = q0.pop_front();
        compare_done("s0", mon_e0, cyc, bus0.err_cnt, bus0.pass, bus0.a, bus0.b,
                     bus0.busy, fi0, fv0);
      end
    end
  end

  function automatic logic [6:0] corr_word(input int mode, input int i);
    if (mode == 0) return 7'd0;
    if (mode == 1) return TT[i] & 7'b0000010;   // xor output stuck at 0
    return ($urandom_range(0, 2) == 0) ? 7'($urandom_range(1, 127)) : 7'd0;
  endfunction

  task automatic set_corr(input int sel, input int mode);
    for (int i = 0; i < 4; i++) begin
      if (sel == 0) corr0[i] = corr_word(mode, i);
      else          corr2[i] = corr_word(mode, i);
    end
  endtask

  // Called at a negedge: pulse start for one cycle and queue the expectation.
  task automatic launch(input int sel);
    if (sel == 0) begin
      last0 = model(corr0, cyc + 1 + 4 * 2 + 1);
      q0.push_back(last0);
      bus0.start = 1'b1;
    end else begin
      last2 = model(corr2, cyc + 1 + 4 * 4 + 1);
      q2.push_back(last2);
      bus2.start = 1'b1;
    end
    @(negedge clk);
    bus0.start = 1'b0;
    bus2.start = 1'b0;
    check("busy_after_start", (sel == 0) ? bus0.busy : bus2.busy, 1'b1);
  endtask

  task automatic wait_idle(input int sel);
    for (int k = 0; k < 100; k++) begin
      if (((sel == 0) ? q0.size() : q2.size()) == 0) break;
      @(negedge clk);
    end
    check("run_timeout", (sel == 0) ? q0.size() : q2.size(), 0);
    q0.delete();
    q2.delete();
    repeat (3) @(negedge clk);
    if (sel == 0) begin
      check("s0_err_hold", bus0.err_cnt, last0.err);
      check("s0_pass_hold", bus0.pass, last0.pass);
      check("s0_ab_hold", {bus0.a, bus0.b}, 2'b11);
    end else begin
      check("s2_err_hold", bus2.err_cnt, last2.err);
      check("s2_pass_hold", bus2.pass, last2.pass);
      check("s2_ab_hold", {bus2.a, bus2.b}, 2'b11);
    end
  endtask

  task automatic run(input int sel, input int mode);
    set_corr(sel, mode);
    launch(sel);
    wait_idle(sel);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, bus2.busy, 1'b0);
    check({tag, "_done"}, bus2.done, 1'b0);
    check({tag, "_pass"}, bus2.pass, 1'b0);
    check({tag, "_err"}, bus2.err_cnt, 3'd0);
    check({tag, "_ab"}, {bus2.a, bus2.b}, 2'b00);
`ifdef GATE_EX_FIRST_FAIL_EN
    check({tag, "_fidx"}, bus2.fail_idx, 2'd0);
    check({tag, "_fvec"}, bus2.fail_vec, 7'd0);
`endif
  endtask

  initial begin
    int samp;
    rst_n = 1'b0;
    bus2.start = 1'b0;
    bus0.start = 1'b0;
    set_corr(0, 0);
    set_corr(2, 0);
    repeat (3) @(negedge clk);
    check_zero("reset");
    check("reset_s0_busy", bus0.busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    run(2, 0);                       // clean gate block
    run(2, 1);                       // xor stuck at 0
    for (int r = 0; r < 6; r++) run(2, 2);

    // start held high: one run, then a second run right after done
    set_corr(2, 0);
    samp = cyc + 1;
    last2 = model(corr2, samp + 17);
    q2.push_back(last2);
    last2 = model(corr2, samp + 17 + 17 + 1);
    q2.push_back(last2);
    bus2.start = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (cyc >= samp + 18) break;
      @(negedge clk);
    end
    check("held_start_rerun_busy", bus2.busy, 1'b1);
    bus2.start = 1'b0;
    wait_idle(2);

    // reset during DRIVE of vector 2 aborts the run
    set_corr(2, 2);
    samp = cyc + 1;
    launch(2);
    for (int k = 0; k < 20; k++) begin
      if (cyc >= samp + 8) break;
      @(negedge clk);
    end
    rst_n = 1'b0;
    q2.delete();
    #1;
    check_zero("midrun_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);      // any done here hits an empty queue
    run(2, 2);
    run(2, 1);

    // zero settle cycles
    run(0, 0);
    run(0, 1);
    for (int r = 0; r < 4; r++) run(0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d expected 0 pending", q2.size() + q0.size());
    $fatal(1);
  end

endmodule

// File: doc/gate_exerciser.md
GATE_EXERCISER -- requirements
Module: gate_exerciser

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, is the number of wait cycles between driving a/b and sampling gate_in, with a legal range of 0..15.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 start  input  1  request one full exercise run; sampled only in IDLE.
REQ-005 busy  output  1  high while a run is in progress (any state except IDLE).
REQ-006 done  output  1  one-cycle pulse at end of run.
REQ-007 pass  output  1  run result: 1 when err_cnt==0; valid from done until next start.
REQ-008 a  output  1  stimulus operand a to the downstream gate block.
REQ-009 b  output  1  stimulus operand b to the downstream gate block.
REQ-010 gate_in  input  7  gate block results: [6]and [5]or [4]nand [3]nor [2]not(~a) [1]xor [0]xnor.
REQ-011 err_cnt  output  3  count of mismatching vectors in the current/last run, range 0..4.
REQ-012 fail_idx  output  2  index of the first failing vector (present only with GATE_EX_FIRST_FAIL_EN).
REQ-013 fail_vec  output  7  gate_in captured at the first failing vector (present only with GATE_EX_FIRST_FAIL_EN).

Function
REQ-014 The FSM SHALL have states IDLE, DRIVE, SETTLE, CHECK and DONE.
REQ-015 IDLE -> DRIVE when start=1; on that edge, clear err_cnt, pass, fail_idx, fail_vec and vector index idx.
REQ-016 DRIVE shall register {a,b} = idx, with idx 0..3 giving 00,01,10,11 ({a,b}=2'b01 means a=0, b=1); DRIVE -> SETTLE, or -> CHECK if SETTLE_CYCLES==0.
REQ-017 SETTLE shall stay for exactly SETTLE_CYCLES cycles using an internal counter, then go -> CHECK.
REQ-018 CHECK shall compare gate_in with the expected 7-bit truth-table value for the current {a,b} and increment err_cnt by 1 on any bit mismatch.
REQ-019 CHECK shall go -> DRIVE with idx+1 when idx<3, and -> DONE when idx==3; idx shall not wrap inside a run.
REQ-020 DONE shall assert done for one cycle, set pass=(err_cnt==0 including the final check), then go -> IDLE.
REQ-021 Latency: done shall be high exactly 4*(2+SETTLE_CYCLES)+1 cycles after the clk edge that sampled start.
REQ-022 start while busy shall be ignored with no restart and no effect on counters.
REQ-023 a and b shall hold their last driven values in IDLE after a run.
REQ-024 err_cnt and pass shall hold their values in IDLE until the next accepted start.
REQ-025 All outputs shall be registered, with no combinational path from gate_in or start to any output.

Reset
REQ-026 While rst_n=0, state shall be IDLE and a, b, busy, done, pass, err_cnt, fail_idx, fail_vec, idx and the settle counter shall all be 0.
REQ-027 Reset asserted mid-run shall abort the run with no done pulse; the first start after release shall begin a fresh run from idx 0.

Configuration
REQ-028 With macro GATE_EX_FIRST_FAIL_EN defined, ports fail_idx/fail_vec shall exist; on the first mismatching CHECK of a run (err_cnt==0 before it), they shall capture idx and gate_in, and later mismatches shall not overwrite them.
REQ-029 Without GATE_EX_FIRST_FAIL_EN, the fail_idx/fail_vec ports and their registers shall not exist and all other behaviour shall be identical.

Structure
REQ-030 Shared package gate_ex_pkg shall hold the FSM state enum, constants GATE_W=7, NUM_VECTORS=4 and bit-position constants for gate_in, and a function returning the expected 7-bit value for (a,b).
REQ-031 No sub-module: the expected model shall be the package function and the FSM shall live in gate_exerciser.

Verification
REQ-032 Correct gate model on gate_in, SETTLE_CYCLES=2, start pulse -> done 17 cycles later, pass=1, err_cnt=0, {a,b} stepping 00,01,10,11.
REQ-033 xor bit forced to 0 -> err_cnt=2, pass=0; with the macro, fail_idx=1 and fail_vec=7'b0110100.
REQ-034 start held high for the entire run -> exactly one run and one done pulse, then a new run starts on the cycle after returning to IDLE.
REQ-035 rst_n pulsed low during DRIVE of idx 2 -> all outputs 0 immediately and no done pulse; the next start gives a complete 4-vector run.
REQ-036 SETTLE_CYCLES=0 -> done 9 cycles after start, with correct pass/err_cnt.
REQ-037 Build without GATE_EX_FIRST_FAIL_EN -> REQ-032 and REQ-033 results match for pass/err_cnt, and the fail ports are absent.
